// File: rtl/sprite_compositor_if.sv
// Pixel-side bundle for sprite_compositor: per-pixel layer data, frame/fade/blink controls,
// and the registered RGB plus fade status returned toward the DAC.
interface sprite_compositor_if #(
    parameter int unsigned NUM_LAYERS = 4
);
    logic                       frame_start;
    logic                       vid_on;
    logic [9:0]                 DrawX;
    logic [9:0]                 DrawY;
    logic [NUM_LAYERS-1:0]      layer_hit;
    logic [24*NUM_LAYERS-1:0]   layer_rgb;
    logic [23:0]                ground_rgb;
    logic [23:0]                sky_rgb;
    logic [NUM_LAYERS-1:0]      blink_req;
    logic                       fade_start;
    logic [7:0]                 Red;
    logic [7:0]                 Green;
    logic [7:0]                 Blue;
    logic                       fade_busy;
    logic                       fade_dark;

    modport master (
        output frame_start, vid_on, DrawX, DrawY, layer_hit, layer_rgb,
        output ground_rgb, sky_rgb, blink_req, fade_start,
        input  Red, Green, Blue, fade_busy, fade_dark
    );

    modport slave (
        input  frame_start, vid_on, DrawX, DrawY, layer_hit, layer_rgb,
        input  ground_rgb, sky_rgb, blink_req, fade_start,
        output Red, Green, Blue, fade_busy, fade_dark
    );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage priority compositor: stage 1 captures the pixel inputs, stage 2 picks a colour
// (layers, ground, sky) and applies per-layer blink hiding and the frame-stepped fade.
module sprite_compositor #(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter logic [9:0]  GROUND_Y     = 10'd416,
    parameter logic [23:0] KEY_RGB      = 24'hFF00FF,
    parameter int unsigned BLINK_FRAMES = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    sprite_compositor_if.slave bus
);

    typedef enum logic [1:0] {StRun, StDarken, StDark, StBrighten} fade_state_e;

    // Stage 1 registers
    logic                     vid_q, vid_d;
    logic                     below_q, below_d;
    logic [NUM_LAYERS-1:0]    hit_q, hit_d;
    logic [24*NUM_LAYERS-1:0] rgb_q, rgb_d;
    logic [23:0]              ground_q, ground_d;
    logic [23:0]              sky_q, sky_d;

    // Stage 2 registers
    logic [7:0] red_q, red_d;
    logic [7:0] green_q, green_d;
    logic [7:0] blue_q, blue_d;

    logic [NUM_LAYERS-1:0][7:0] blink_cnt_q, blink_cnt_d;

    fade_state_e state_q, state_d;
    logic [2:0]  level_q, level_d;
    logic        busy_q, busy_d;
    logic        dark_q, dark_d;

    logic        unused_drawx;
    logic [23:0] sel_rgb;

    assign unused_drawx = ^bus.DrawX;

    always_comb begin
        vid_d    = bus.vid_on;
        below_d  = (bus.DrawY >= GROUND_Y);
        hit_d    = bus.layer_hit;
        rgb_d    = bus.layer_rgb;
        ground_d = bus.ground_rgb;
        sky_d    = bus.sky_rgb;
    end

    // A request outranks a coincident frame_start so a retrigger always lands on a full count.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            if (bus.blink_req[i]) begin
                blink_cnt_d[i] = 8'(BLINK_FRAMES);
            end else if (bus.frame_start && (blink_cnt_q[i] != 8'd0)) begin
                blink_cnt_d[i] = blink_cnt_q[i] - 8'd1;
            end
        end
    end

    // Scan from lowest priority upward so the lowest eligible index is the last to assign.
    always_comb begin
        sel_rgb = below_q ? ground_q : sky_q;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (hit_q[i] && (rgb_q[24*i +: 24] != KEY_RGB) && !blink_cnt_q[i][0]) begin
                sel_rgb = rgb_q[24*i +: 24];
            end
        end
    end

    always_comb begin
        red_d   = 8'd0;
        green_d = 8'd0;
        blue_d  = 8'd0;
        if (vid_q && (level_q < 3'd4)) begin
            red_d   = sel_rgb[23:16] >> level_q;
            green_d = sel_rgb[15:8]  >> level_q;
            blue_d  = sel_rgb[7:0]   >> level_q;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vid_q       <= 1'b0;
            below_q     <= 1'b0;
            hit_q       <= '0;
            rgb_q       <= '0;
            ground_q    <= '0;
            sky_q       <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            blink_cnt_q <= '0;
        end else begin
            vid_q       <= vid_d;
            below_q     <= below_d;
            hit_q       <= hit_d;
            rgb_q       <= rgb_d;
            ground_q    <= ground_d;
            sky_q       <= sky_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    // Fade sequencer: state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StRun;
            level_q <= 3'd0;
            busy_q  <= 1'b0;
            dark_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            busy_q  <= busy_d;
            dark_q  <= dark_d;
        end
    end

    // Fade sequencer: next state
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            StRun: begin
                level_d = 3'd0;
                if (bus.fade_start) state_d = StDarken;
            end
            StDarken: begin
                if (bus.frame_start) begin
                    level_d = level_q + 3'd1;
                    if (level_q == 3'd3) state_d = StDark;
                end
            end
            StDark: begin
                level_d = 3'd4;
                if (bus.fade_start) state_d = StBrighten;
            end
            StBrighten: begin
                if (bus.frame_start) begin
                    level_d = level_q - 3'd1;
                    if (level_q == 3'd1) state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                level_d = 3'd0;
            end
        endcase
    end

    // Fade sequencer: status decoded from the next state so flags move with the state edge
    always_comb begin
        busy_d = (state_d == StDarken) || (state_d == StBrighten);
        dark_d = (state_d == StDark);
    end

    assign bus.Red       = red_q;
    assign bus.Green     = green_q;
    assign bus.Blue      = blue_q;
    assign bus.fade_busy = busy_q;
    assign bus.fade_dark = dark_q;

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised pixel compositor that replaces the fixed two-sprite colour mapper. It merges NUM_LAYERS sprite layers by fixed priority, honours a transparency colour key, and falls back to ground and sky colours. Per-layer frame-counted blink (damage flash) and a frame-stepped fade-to-black/fade-in sequencer are included. It sits between the sprite/ROM units and the VGA DAC, with registered RGB outputs at a fixed 2-cycle latency.

## Interface
- NUM_LAYERS, 4: sprite layer count, 1..8; layer 0 has highest priority.
- GROUND_Y, 416: first DrawY row drawn as ground.
- KEY_RGB, 24'hFF00FF: transparent colour; a layer pixel equal to it never wins.
- BLINK_FRAMES, 8: frames a blink lasts after a request, 1..255.
- Clk  in  1  pixel clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state and outputs.
- frame_start  in  1  one-cycle pulse at start of each frame (vsync edge).
- vid_on  in  1  active-video flag.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- layer_hit  in  NUM_LAYERS  bit i set when layer i covers this pixel.
- layer_rgb  in  24*NUM_LAYERS  layer i pixel at [24i+23:24i], R in the top byte.
- ground_rgb, sky_rgb  in  24 each  background colours.
- blink_req  in  NUM_LAYERS  bit i pulse starts or restarts the blink of layer i.
- fade_start  in  1  pulse that advances the fade sequencer.
- Red, Green, Blue  out  8 each  registered pixel colour.
- fade_busy  out  1  high in DARKEN or BRIGHTEN.
- fade_dark  out  1  high in DARK.

## Operation
- Stage 1 registers vid_on, DrawY compare, layer_hit, layer_rgb, ground_rgb and sky_rgb.
- Stage 2 selects the colour and registers RGB.
- A layer is eligible when layer_hit[i]=1, layer_rgb_i != KEY_RGB, and the layer is not blink-hidden.
- Colour selection order:
  - lowest-index eligible layer;
  - otherwise ground_rgb if DrawY >= GROUND_Y;
  - otherwise sky_rgb.
- When vid_on=0 at stage 1, the output is 0.
- Blink:
  - blink_cnt[i] is 8 bits.
  - blink_req[i] loads BLINK_FRAMES.
  - Each frame_start decrements every non-zero counter.
  - Layer i is hidden while blink_cnt[i][0]=1, so it is on/off on alternating frames.
  - If blink_req[i] and frame_start coincide, the load wins.
  - A retrigger mid-blink reloads the counter.
- Fade FSM states: RUN, DARKEN, DARK, BRIGHTEN. level is 3 bits, range 0..4.
  - RUN: level=0. fade_start moves to DARKEN.
  - DARKEN: each frame_start increments level; the frame_start that sets level to 4 also moves to DARK.
  - DARK: level=4. fade_start moves to BRIGHTEN.
  - BRIGHTEN: each frame_start decrements level; reaching 0 moves to RUN.
  - fade_start is ignored in DARKEN and BRIGHTEN.
- Fade application: each selected channel is shifted right by level; level 4 forces 0. The fade is applied at stage 2 using the current level register.

## Timing
- Reset values:
  - Red, Green, Blue = 0;
  - fade_busy = 0, fade_dark = 0;
  - FSM = RUN, level = 0;
  - all blink_cnt = 0;
  - pipeline registers = 0.
- Latency: inputs sampled at edge t give RGB at edge t+2, with one result per cycle and no stalls.
- Blink and fade register updates take effect for pixels reaching stage 2 on the cycle after the update edge.
- fade_busy and fade_dark are registered decodes of the state, updating on the same edge as the state.
- Reset asserted mid-frame or mid-fade zeroes the outputs immediately (asynchronously) and restarts in RUN with no blinks active.

## Test plan
- Setup for the first four scenarios: NUM_LAYERS=4, vid_on=1, DrawY=100.
- Priority: layer_hit=4'b0110, layer1=24'h112233, layer2=24'h445566 -> RGB 11/22/33 two cycles later.
- Transparency:
  - layer_hit=4'b0010 with layer1=KEY_RGB, DrawY=100 -> sky_rgb.
  - Same with DrawY=416 -> ground_rgb.
  - Same with vid_on=0 -> 00/00/00.
- Blink: pulse blink_req[0] with layer 0 only hit, then 8 frame_starts -> layer 0 shown on even-counter frames, hidden (sky) on odd; visible permanently after the 8th frame. A blink_req[0] coinciding with a frame_start reloads to 8.
- Fade:
  - Sky=24'hF0F0F0; fade_start then 4 frame_starts -> output F0, 78, 3C, 1E, 00; fade_dark=1 after the 4th frame_start.
  - Second fade_start then 4 frame_starts -> the sequence reverses and the FSM returns to RUN.
  - fade_start during DARKEN -> no change.
- Reset: assert Reset during DARKEN with an active blink -> RGB=0 immediately; after release, fade_busy=0, level=0, no layer hidden.
